// File: rtl/q2_i2c_master.sv
// q2_i2c_master: CPU-commanded I2C master producing START, STOP, byte write and
// byte read on open-drain SCL/SDA, with slave clock stretching honoured in P1.
module q2_i2c_master #(
    parameter int DIV = 25
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr,
    input  logic        rd,
    inout  wire  [11:0] dbus,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        scl_oe,
    output logic        sda_oe
);
    localparam int CW = $clog2(DIV + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    localparam logic [3:0] OP_START  = 4'd1;
    localparam logic [3:0] OP_STOP   = 4'd2;
    localparam logic [3:0] OP_WRITE  = 4'd3;
    localparam logic [3:0] OP_RDACK  = 4'd4;
    localparam logic [3:0] OP_RDNACK = 4'd5;

    typedef enum logic [1:0] {S_IDLE, S_START, S_STOP, S_BIT} state_t;

    state_t          state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      bit_q, bit_d;
    logic [3:0]      op_q, op_d;
    logic [7:0]      tx_q, tx_d;
    logic [7:0]      rxShift_q, rxShift_d;
    logic [7:0]      rx_q, rx_d;
    logic            nack_q, nack_d;
    logic            overrun_q, overrun_d;
    logic            rxValid_q, rxValid_d;
    logic            sclOe_q, sclOe_d;
    logic            sdaOe_q, sdaOe_d;
    logic            busy;
    logic            bitVal;
    logic [11:0]     status;

    assign busy   = (state_q != S_IDLE);
    assign status = {busy, nack_q, overrun_q, rxValid_q, rx_q};
    assign dbus   = rd ? status : 12'bz;
    assign scl_oe = sclOe_q;
    assign sda_oe = sdaOe_q;

    // Command acceptance, phase/bit sequencing and flag bookkeeping.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        op_d      = op_q;
        tx_d      = tx_q;
        rxShift_d = rxShift_q;
        rx_d      = rx_q;
        nack_d    = nack_q;
        overrun_d = overrun_q;
        rxValid_d = rxValid_q;

        if (rd) begin
            overrun_d = 1'b0;
            rxValid_d = 1'b0;
        end

        if (state_q == S_IDLE) begin
            if (wr) begin
                case (dbus[11:8])
                    OP_START:                      state_d = S_START;
                    OP_STOP:                       state_d = S_STOP;
                    OP_WRITE, OP_RDACK, OP_RDNACK: state_d = S_BIT;
                    default:                       state_d = S_IDLE;
                endcase
                if (state_d != S_IDLE) begin
                    op_d    = dbus[11:8];
                    tx_d    = dbus[7:0];
                    phase_d = 2'd0;
                    cnt_d   = '0;
                    bit_d   = 4'd0;
                end
            end
        end else begin
            if (wr) begin
                overrun_d = 1'b1;
            end
            // In P1 a low SCL (ours or a stretching slave) restarts the high-time count.
            if (phase_q == 2'd1 && !scl_i) begin
                cnt_d = '0;
            end else if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d   = '0;
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd2 && state_q == S_BIT) begin
                    if (bit_q < 4'd8) begin
                        rxShift_d = {rxShift_q[6:0], sda_i};
                    end else if (op_q == OP_WRITE) begin
                        nack_d = sda_i;
                    end
                end
                if (phase_q == 2'd3) begin
                    if (state_q != S_BIT || bit_q == 4'd8) begin
                        state_d = S_IDLE;
                        if (op_q == OP_RDACK || op_q == OP_RDNACK) begin
                            rx_d      = rxShift_q;
                            rxValid_d = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
        end
    end

    // Line drive follows the phase being entered, so the pins are registered.
    always_comb begin
        sclOe_d = sclOe_q;
        sdaOe_d = sdaOe_q;
        if (bit_d < 4'd8) begin
            bitVal = (op_d == OP_WRITE) ? tx_d[~bit_d[2:0]] : 1'b1;
        end else begin
            bitVal = (op_d != OP_RDACK);
        end
        case (state_d)
            S_START: begin
                case (phase_d)
                    2'd0:    sdaOe_d = 1'b0;
                    2'd1:    sclOe_d = 1'b0;
                    2'd2:    sdaOe_d = 1'b1;
                    default: sclOe_d = 1'b1;
                endcase
            end
            S_STOP: begin
                case (phase_d)
                    2'd0:    sdaOe_d = 1'b1;
                    2'd1:    sclOe_d = 1'b0;
                    2'd2:    sdaOe_d = 1'b0;
                    default: ;
                endcase
            end
            S_BIT: begin
                case (phase_d)
                    2'd0: begin
                        sclOe_d = 1'b1;
                        sdaOe_d = !bitVal;
                    end
                    2'd1:    sclOe_d = 1'b0;
                    2'd2:    ;
                    default: sclOe_d = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            phase_q   <= 2'd0;
            cnt_q     <= '0;
            bit_q     <= 4'd0;
            op_q      <= 4'd0;
            tx_q      <= 8'h00;
            rxShift_q <= 8'h00;
            rx_q      <= 8'h00;
            nack_q    <= 1'b0;
            overrun_q <= 1'b0;
            rxValid_q <= 1'b0;
            sclOe_q   <= 1'b0;
            sdaOe_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            op_q      <= op_d;
            tx_q      <= tx_d;
            rxShift_q <= rxShift_d;
            rx_q      <= rx_d;
            nack_q    <= nack_d;
            overrun_q <= overrun_d;
            rxValid_q <= rxValid_d;
            sclOe_q   <= sclOe_d;
            sdaOe_q   <= sdaOe_d;
        end
    end

endmodule

// File: tb/tb_q2_i2c_master.sv
// Testbench for q2_i2c_master (DIV=2): open-drain bus with a behavioural slave,
// scoreboarded status reads and a bit monitor checking SDA at each SCL rise.
module tb_q2_i2c_master;
    localparam int DIV = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [11:0] cmdBus = 12'h000;
    wire  [11:0] dbus;
    logic        scl_oe, sda_oe;
    wire         sclLine, sdaLine;

    logic        slaveHold = 1'b0;
    logic        slaveSda = 1'b1;
    int          slaveMode = 0;
    logic [7:0]  slaveByte = 8'h00;
    int          fallCnt = 0;

    int          errors = 0;
    int          checks = 0;
    int          startCnt = 0;
    int          stopCnt = 0;
    logic        pollMode = 1'b0;
    logic        checkBits = 1'b0;
    logic [11:0] expQ[$];
    logic        expBits[$];

    assign dbus    = (wr && !rd) ? cmdBus : 12'bz;
    assign sclLine = !scl_oe && !slaveHold;
    assign sdaLine = !sda_oe && slaveSda;

    q2_i2c_master #(.DIV(DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .wr     (wr),
        .rd     (rd),
        .dbus   (dbus),
        .scl_i  (sclLine),
        .sda_i  (sdaLine),
        .scl_oe (scl_oe),
        .sda_oe (sda_oe)
    );

    always #5 clk = ~clk;

    // Slave: mode 1 acks a written byte, mode 2 returns slaveByte MSB first.
    always @(negedge sclLine) begin
        logic [2:0] idx;
        fallCnt = fallCnt + 1;
        if (slaveMode == 1) begin
            slaveSda = (fallCnt == 8) ? 1'b0 : 1'b1;
        end else if (slaveMode == 2) begin
            if (fallCnt <= 7) begin
                idx = 3'(7 - fallCnt);
                slaveSda = slaveByte[idx];
            end else begin
                slaveSda = 1'b1;
            end
        end
    end

    always @(negedge sdaLine) if (sclLine === 1'b1) startCnt = startCnt + 1;
    always @(posedge sdaLine) if (sclLine === 1'b1) stopCnt = stopCnt + 1;

    always @(posedge sclLine) begin
        logic expBit;
        if (checkBits) begin
            checks = checks + 1;
            if (expBits.size() == 0) begin
                errors = errors + 1;
                $display("[TB] FAIL bitMonitor: unexpected SCL rise, sda=%b required no rise", sdaLine);
            end else begin
                expBit = expBits.pop_front();
                if (sdaLine !== expBit) begin
                    errors = errors + 1;
                    $display("[TB] FAIL bitMonitor: sda=%b required %b at %0t", sdaLine, expBit, $time);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [11:0] expStatus;
        if (rd && !pollMode) begin
            checks = checks + 1;
            if (expQ.size() == 0) begin
                errors = errors + 1;
                $display("[TB] FAIL status: read 0x%03h with no expectation queued", dbus);
            end else begin
                expStatus = expQ.pop_front();
                if (dbus !== expStatus) begin
                    errors = errors + 1;
                    $display("[TB] FAIL status: got 0x%03h required 0x%03h at %0t", dbus, expStatus, $time);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [11:0] cmd);
        @(posedge clk);
        #1;
        cmdBus = cmd;
        wr = 1'b1;
        @(posedge clk);
        #1;
        wr = 1'b0;
    endtask

    task automatic readStatus(input logic [11:0] exp);
        expQ.push_back(exp);
        @(posedge clk);
        #1;
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
    endtask

    task automatic waitIdle(output int cyc);
        cyc = 0;
        pollMode = 1'b1;
        rd = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!dbus[11]) break;
            cyc = cyc + 1;
        end
        rd = 1'b0;
        pollMode = 1'b0;
        if (cyc >= 400) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("[TB] FAIL busyTimeout: busy still %b after %0d cycles, required 0", dbus[11], cyc);
        end
    endtask

    task automatic pushBits(input logic [7:0] data, input logic ninth);
        for (int i = 7; i >= 0; i--) expBits.push_back(data[i]);
        expBits.push_back(ninth);
    endtask

    task automatic startSlave(input int mode, input logic [7:0] data);
        slaveMode = mode;
        slaveByte = data;
        fallCnt = 0;
        slaveSda = (mode == 2) ? data[7] : 1'b1;
    endtask

    initial begin
        int cyc;
        int startBefore;
        int stopBefore;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("resetSclOe", int'(scl_oe), 0);
        checkOutput("resetSdaOe", int'(sda_oe), 0);
        rst = 1'b0;
        readStatus(12'h000);

        startBefore = startCnt;
        applyStimulus(12'h100);
        waitIdle(cyc);
        checkOutput("startCycles", cyc, 4 * DIV);
        checkOutput("startCond", startCnt - startBefore, 1);

        startSlave(1, 8'h00);
        pushBits(8'hA4, 1'b0);
        checkBits = 1'b1;
        applyStimulus(12'h3A4);
        waitIdle(cyc);
        checkBits = 1'b0;
        checkOutput("writeCycles", cyc, 36 * DIV);
        checkOutput("writeBitsLeft", expBits.size(), 0);
        readStatus(12'h000);

        startSlave(2, 8'h5C);
        pushBits(8'h5C, 1'b1);
        checkBits = 1'b1;
        applyStimulus(12'h500);
        waitIdle(cyc);
        checkBits = 1'b0;
        startSlave(0, 8'h00);
        checkOutput("readCycles", cyc, 36 * DIV);
        checkOutput("readBitsLeft", expBits.size(), 0);
        readStatus(12'h15C);
        readStatus(12'h05C);

        startSlave(1, 8'h00);
        pushBits(8'h3C, 1'b0);
        checkBits = 1'b1;
        applyStimulus(12'h33C);
        fork
            waitIdle(cyc);
            begin
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if (fallCnt == 3) break;
                end
                slaveHold = 1'b1;
                repeat (14) @(negedge clk);
                slaveHold = 1'b0;
            end
        join
        checkBits = 1'b0;
        checkOutput("stretchCycles", cyc, 36 * DIV + 10);
        checkOutput("stretchBitsLeft", expBits.size(), 0);
        readStatus(12'h05C);

        startSlave(1, 8'h00);
        pushBits(8'h81, 1'b0);
        checkBits = 1'b1;
        applyStimulus(12'h381);
        repeat (10) @(posedge clk);
        #1;
        cmdBus = 12'h3FF;
        wr = 1'b1;
        @(posedge clk);
        #1;
        expQ.push_back(12'hA5C);
        rd = 1'b1;
        @(posedge clk);
        #1;
        expQ.push_back(12'hA5C);
        wr = 1'b0;
        @(posedge clk);
        #1;
        rd = 1'b0;
        waitIdle(cyc);
        checkBits = 1'b0;
        checkOutput("overrunBitsLeft", expBits.size(), 0);
        readStatus(12'h05C);

        startBefore = startCnt;
        stopBefore = stopCnt;
        applyStimulus(12'h100);
        waitIdle(cyc);
        checkOutput("rstartCycles", cyc, 4 * DIV);
        checkOutput("rstartCond", startCnt - startBefore, 1);
        checkOutput("rstartNoStop", stopCnt - stopBefore, 0);
        checkOutput("rstartScl", int'(sclLine), 0);
        checkOutput("rstartSda", int'(sdaLine), 0);

        stopBefore = stopCnt;
        applyStimulus(12'h200);
        waitIdle(cyc);
        checkOutput("stopCycles", cyc, 4 * DIV);
        checkOutput("stopCond", stopCnt - stopBefore, 1);
        checkOutput("stopSclOe", int'(scl_oe), 0);
        checkOutput("stopSdaOe", int'(sda_oe), 0);

        startSlave(1, 8'h00);
        applyStimulus(12'h300);
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midRstSclOe", int'(scl_oe), 0);
        checkOutput("midRstSdaOe", int'(sda_oe), 0);
        readStatus(12'h000);
        startSlave(0, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        startBefore = startCnt;
        applyStimulus(12'h100);
        waitIdle(cyc);
        checkOutput("postRstStartCycles", cyc, 4 * DIV);
        checkOutput("postRstStartCond", startCnt - startBefore, 1);
        checkOutput("postRstScl", int'(sclLine), 0);

        repeat (2) @(posedge clk);
        checkOutput("statusQueueLeft", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
